conv_weight_loader: RTL and testbench

CONV_WEIGHT_LOADER -- requirements
Module: conv_weight_loader

---
 rtl/conv_weight_loader.sv | 74 +++++++
 tb/tb_conv_weight_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/conv_weight_loader.sv
// Streams NUM_WORDS weight words into a conv layer's weight port. Each write appears 1 cycle after its beat is accepted.
// s_ready is high only in LOAD with no abort. s_valid gaps stall the load indefinitely.
module conv_weight_loader #(
  parameter int unsigned BASE_ADDR = 17176,
  parameter int unsigned NUM_WORDS = 9250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  output logic        busy,
  output logic        done,
  output logic        loaded
);

  localparam logic [23:0] LAST_CNT = 24'(NUM_WORDS - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state;
  logic [23:0] cnt;

  assign s_ready = (state == LOAD) && !abort;
  assign busy    = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_data <= '0;
      weight_wr_addr <= '0;
      done           <= 1'b0;
      loaded         <= 1'b0;
    end else begin
      weight_wr_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= LOAD;
            cnt    <= '0;
            loaded <= 1'b0;
          end
        end
        LOAD: begin
          // abort discards the partial load; loaded stays low from the start cycle
          if (abort) begin
            state <= IDLE;
          end else if (s_valid) begin
            weight_wr_en   <= 1'b1;
            weight_wr_data <= s_data;
            weight_wr_addr <= BASE + {8'd0, cnt};
            cnt            <= cnt + 24'd1;
            if (cnt == LAST_CNT) begin
              state  <= IDLE;
              done   <= 1'b1;
              loaded <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: directed vector table, hand-written corner sequences, and random traffic vs a load-level model.
module tb_conv_weight_loader;

  localparam int unsigned BASE = 100;
  localparam int unsigned NW   = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort, s_valid;
  logic [15:0] s_data;
  logic        s_ready, weight_wr_en, busy, done, loaded;
  logic [15:0] weight_wr_data;
  logic [31:0] weight_wr_addr;

  conv_weight_loader #(.BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
    .weight_wr_en(weight_wr_en), .busy(busy), .done(done), .loaded(loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;

  // Load-level reference: is a load open, how many words written so far, last write seen.
  bit          m_busy, m_loaded, m_wen, m_done;
  int unsigned m_n;
  logic [31:0] m_addr;
  logic [15:0] m_data;
  logic        obs_ready;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic ab, input logic v,
                      input logic [15:0] d);
    rst = r; start = st; abort = ab; s_valid = v; s_data = d;
    #1;
    obs_ready = s_ready;
    chk("s_ready", {31'd0, s_ready}, {31'd0, m_busy && !ab});
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = 0; m_n = 0; m_loaded = 0; m_wen = 0; m_done = 0;
      m_addr = '0; m_data = '0;
    end else begin
      m_wen = 0; m_done = 0;
      if (!m_busy) begin
        if (st && !ab) begin m_busy = 1; m_n = 0; m_loaded = 0; end
      end else if (ab) begin
        m_busy = 0;
      end else if (v) begin
        m_wen  = 1;
        m_data = d;
        m_addr = BASE + m_n;
        m_n++;
        if (m_n == NW) begin m_busy = 0; m_done = 1; m_loaded = 1; end
      end
    end
    if (weight_wr_en === 1'b1) wr_seen++;
    chk("wr_en",   {31'd0, weight_wr_en}, {31'd0, m_wen});
    chk("wr_addr", weight_wr_addr, m_addr);
    chk("wr_data", {16'd0, weight_wr_data}, {16'd0, m_data});
    chk("done",    {31'd0, done}, {31'd0, m_done});
    chk("loaded",  {31'd0, loaded}, {31'd0, m_loaded});
    chk("busy",    {31'd0, busy}, {31'd0, m_busy});
  endtask

  task automatic word(input logic [15:0] d);
    step(0, 0, 0, 1, d);
  endtask

  typedef struct {
    logic        rst, start, abort, valid;
    logic [15:0] data;
    logic        ready, wen;
    logic [31:0] addr;
    logic [15:0] wdat;
    logic        done, loaded, busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // rst st ab v data | ready wen addr wdat done loaded busy
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0,   16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hA0A1, 1'b1, 1'b1, 32'd100, 16'hA0A1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hB0B2, 1'b1, 1'b1, 32'd101, 16'hB0B2, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hC0C3, 1'b1, 1'b1, 32'd102, 16'hC0C3, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hD0D4, 1'b1, 1'b1, 32'd103, 16'hD0D4, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 32'd103, 16'hD0D4, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 32'd103, 16'hD0D4, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd103, 16'hD0D4, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hE0E5, 1'b1, 1'b1, 32'd100, 16'hE0E5, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hF0F6, 1'b0, 1'b0, 32'd100, 16'hE0E5, 1'b0, 1'b0, 1'b0};

    rst = 1; start = 0; abort = 0; s_valid = 0; s_data = '0;
    m_busy = 0; m_n = 0; m_loaded = 0; m_wen = 0; m_done = 0; m_addr = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",   {31'd0, weight_wr_en}, 32'd0);
    chk("rst_wr_addr", weight_wr_addr, 32'd0);
    chk("rst_loaded",  {31'd0, loaded}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);

    // Directed table: basic load, idle-ignores, abort+start in IDLE, reload, abort mid-load
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].valid, tbl[i].data);
      chk($sformatf("tbl%0d_ready", i), {31'd0, obs_ready}, {31'd0, tbl[i].ready});
      chk($sformatf("tbl%0d_wen", i), {31'd0, weight_wr_en}, {31'd0, tbl[i].wen});
      chk($sformatf("tbl%0d_addr", i), weight_wr_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_data", i), {16'd0, weight_wr_data}, {16'd0, tbl[i].wdat});
      chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("tbl%0d_loaded", i), {31'd0, loaded}, {31'd0, tbl[i].loaded});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
    end

    // Stalled load: valid pattern 1,0,0 repeated
    step(0, 1, 0, 0, 16'h0);
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      word(16'h3000 + 16'(i));
      step(0, 0, 0, 0, 16'h5555);
      step(0, 0, 0, 0, 16'h6666);
    end
    chk("stall_writes", wr_seen, 4);
    chk("stall_loaded", {31'd0, loaded}, 32'd1);

    // Abort after two words, with s_valid high in the abort cycle
    step(0, 1, 0, 0, 16'h0);
    wr_seen = 0;
    word(16'h4001); word(16'h4002);
    step(0, 0, 1, 1, 16'h4003);
    chk("abort_ready", {31'd0, obs_ready}, 32'd0);
    step(0, 0, 0, 1, 16'h4004);
    chk("abort_writes", wr_seen, 2);
    chk("abort_loaded", {31'd0, loaded}, 32'd0);

    // start pulsed during the load must not restart addressing
    step(0, 1, 0, 0, 16'h0);
    word(16'h5001); word(16'h5002);
    step(0, 1, 0, 1, 16'h5003);
    chk("midstart_addr", weight_wr_addr, 32'd102);
    word(16'h5004);
    chk("midstart_done", {31'd0, done}, 32'd1);

    // Reset after three words, then a clean load
    step(0, 1, 0, 0, 16'h0);
    word(16'h6001); word(16'h6002); word(16'h6003);
    step(1, 0, 0, 1, 16'h6004);
    chk("rstmid_addr", weight_wr_addr, 32'd0);
    step(0, 0, 0, 1, 16'h6005);
    step(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) word(16'h7000 + 16'(i));
    chk("rstmid_loaded", {31'd0, loaded}, 32'd1);

    // Reload after completion
    step(0, 1, 0, 0, 16'h0);
    chk("reload_loaded", {31'd0, loaded}, 32'd0);
    for (int i = 0; i < 4; i++) word(16'h8000 + 16'(i));
    chk("reload_addr", weight_wr_addr, 32'd103);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, 16'($urandom_range(0, 65535)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
